tpram_arbiter: RTL and testbench
================================

Name: tpram_arbiter

Overview:
- Shares one 256x16 two-port RAM (write port A, registered read port B) between two requester clients, client 0 and client 1.
- Each client owns a write channel and a read channel.
- The write port and the read port are arbitrated independently, each with a 2-way round-robin.
- Read data returns to the granted client one cycle after its grant, tagged by a per-client valid strobe.

Parameters:
AW, 8, address width (RAM depth 2^AW)
DW, 16, data width

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  reset, asynchronous, active-high
w0_req  in  1  client 0 write request
w0_addr  in  AW  client 0 write address
w0_data  in  DW  client 0 write data
w0_gnt  out  1  client 0 write accepted this cycle
w1_req / w1_addr / w1_data / w1_gnt  as client 0, for client 1
r0_req  in  1  client 0 read request
r0_addr  in  AW  client 0 read address
r0_gnt  out  1  client 0 read accepted this cycle
r0_rvalid  out  1  rd_data is for client 0
r1_req / r1_addr / r1_gnt / r1_rvalid  as client 0, for client 1
rd_data  out  DW  read data, shared by both clients
ram_wea  out  1  to RAM write enable
ram_addra  out  AW  to RAM write address
ram_data_a  out  DW  to RAM write data
ram_enb  out  1  to RAM read enable
ram_addrb  out  AW  to RAM read address
ram_data_b  in  DW  from RAM read data (valid 1 cycle after ram_enb)

Behaviour:
- Handshake: a client holds req, addr and data stable until gnt. The transfer completes in the cycle where req and gnt are both high. At most one gnt per port per cycle.
- Grants are combinational from req and the priority pointer, with zero-cycle latency.
- RAM port A is driven combinationally from the winning write client:
  - ram_wea = w0_gnt | w1_gnt.
  - ram_addra and ram_data_a are muxed by the winner.
  - When no grant, the mux selects client 0 and ram_wea = 0.
- RAM port B follows the same scheme: ram_enb = r0_gnt | r1_gnt, ram_addrb muxed by the winner.
- Round-robin, one pointer per port (wr_prio, rd_prio), each 1 bit, giving the favoured client:
  - Single requester: granted immediately, regardless of pointer.
  - Both requesting: the favoured client is granted.
  - On any grant, the pointer is set to the other client. No grant leaves the pointer unchanged.
  - Result: with continuous contention each client gets every other cycle, so waiting is at most 1 cycle.
- Read return: register rd_owner (1 bit) and rd_pend (1 bit) on a read grant.
  - Cycle N+1 after a grant in cycle N: rX_rvalid = 1 for the owner only; rd_data = ram_data_b, or the forwarded value, see Optional Feature.
  - Back-to-back reads are supported: a new grant in cycle N+1 produces rvalid in N+2.
  - rd_data holds ram_data_b combinationally; it is only meaningful while an rvalid is high.
- Write and read to the same address in the same cycle: the RAM returns the old contents (read-before-write), unless forwarding is enabled.
- Reset (asynchronous, active-high): wr_prio = 0, rd_prio = 0, rd_pend = 0, rd_owner = 0, fwd state cleared.
  - While rst is high: all gnt = 0, ram_wea = 0, ram_enb = 0, r0_rvalid = r1_rvalid = 0.
  - A read granted in the cycle before reset asserts is dropped; no rvalid after reset releases.
- No internal buffering: a write request is never lost; it waits until granted.

Optional Feature:
- Macro: TPRAM_ARB_WR_FWD_EN.
- Defined:
  - In the cycle of a read grant, compare ram_addrb with ram_addra while ram_wea = 1.
  - On a match, register the flag and ram_data_a. The next cycle, rd_data returns that registered write data instead of ram_data_b.
  - Net effect: write-before-read semantics for same-cycle collisions. Adds DW+1 flops.
- Not defined: no comparator or flops; rd_data = ram_data_b always, giving old-data semantics.

Test Plan:
- Reset then idle: all gnt/rvalid/ram_wea/ram_enb = 0; release rst; still 0 with no req.
- w0_req, addr 0x10, data 0xABCD alone: w0_gnt same cycle, ram_wea = 1, ram_addra = 0x10. Next, r1_req addr 0x10: r1_gnt, then r1_rvalid = 1 with rd_data = 0xABCD, r0_rvalid = 0.
- w0 and w1 requesting continuously for 6 cycles from reset: grants alternate w0, w1, w0, w1, w0, w1; ram_data_a matches each winner.
- r0 and r1 requesting back-to-back on addrs 0x01/0x02 preloaded 0x1111/0x2222: rvalid alternates r0, r1 each cycle with the matching data, 1-cycle latency.
- Write 0x5555 and read addr 0x20 (old 0x1234) in the same cycle: rd_data = 0x1234 without TPRAM_ARB_WR_FWD_EN, 0x5555 with it.
- Assert rst the cycle after an r0 grant: r0_rvalid stays 0 through and after reset; pointers back to client 0.

Source files
------------

// File: rtl/tpram_arbiter.sv
// Two-client arbiter in front of a two-port RAM: independent round-robin on the write and read ports.
// Optional write-to-read forwarding for same-cycle address collisions: define TPRAM_ARB_WR_FWD_EN.
module tpram_arbiter #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          w0_req,
    input  logic [AW-1:0] w0_addr,
    input  logic [DW-1:0] w0_data,
    output logic          w0_gnt,
    input  logic          w1_req,
    input  logic [AW-1:0] w1_addr,
    input  logic [DW-1:0] w1_data,
    output logic          w1_gnt,

    input  logic          r0_req,
    input  logic [AW-1:0] r0_addr,
    output logic          r0_gnt,
    output logic          r0_rvalid,
    input  logic          r1_req,
    input  logic [AW-1:0] r1_addr,
    output logic          r1_gnt,
    output logic          r1_rvalid,
    output logic [DW-1:0] rd_data,

    output logic          ram_wea,
    output logic [AW-1:0] ram_addra,
    output logic [DW-1:0] ram_data_a,
    output logic          ram_enb,
    output logic [AW-1:0] ram_addrb,
    input  logic [DW-1:0] ram_data_b
);

    logic wr_prio_q, wr_prio_d;
    logic rd_prio_q, rd_prio_d;
    logic rd_pend_q, rd_pend_d;
    logic rd_owner_q, rd_owner_d;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        w0_gnt = 1'b0;
        w1_gnt = 1'b0;
        r0_gnt = 1'b0;
        r1_gnt = 1'b0;
        // Grants are suppressed during reset; a lone requester wins regardless of the pointer.
        if (!rst) begin
            w0_gnt = w0_req & (~w1_req | ~wr_prio_q);
            w1_gnt = w1_req & (~w0_req |  wr_prio_q);
            r0_gnt = r0_req & (~r1_req | ~rd_prio_q);
            r1_gnt = r1_req & (~r0_req |  rd_prio_q);
        end

        wr_prio_d = wr_prio_q;
        if (w0_gnt) begin
            wr_prio_d = 1'b1;
        end else if (w1_gnt) begin
            wr_prio_d = 1'b0;
        end

        rd_prio_d = rd_prio_q;
        if (r0_gnt) begin
            rd_prio_d = 1'b1;
        end else if (r1_gnt) begin
            rd_prio_d = 1'b0;
        end

        rd_pend_d  = r0_gnt | r1_gnt;
        rd_owner_d = rd_pend_d ? r1_gnt : rd_owner_q;
    end

    // With no grant the muxes rest on client 0.
    assign ram_wea    = w0_gnt | w1_gnt;
    assign ram_addra  = w1_gnt ? w1_addr : w0_addr;
    assign ram_data_a = w1_gnt ? w1_data : w0_data;
    assign ram_enb    = r0_gnt | r1_gnt;
    assign ram_addrb  = r1_gnt ? r1_addr : r0_addr;

    assign r0_rvalid = rd_pend_q & ~rd_owner_q;
    assign r1_rvalid = rd_pend_q &  rd_owner_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_prio_q  <= 1'b0;
            rd_prio_q  <= 1'b0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
            wr_prio_q  <= wr_prio_d;
            rd_prio_q  <= rd_prio_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

`ifdef TPRAM_ARB_WR_FWD_EN
    logic          fwd_hit_q, fwd_hit_d;
    logic [DW-1:0] fwd_data_q, fwd_data_d;

    // A read colliding with a same-cycle write returns the new data instead of the RAM's old contents.
    always_comb begin
        fwd_hit_d  = ram_enb & ram_wea & (ram_addrb == ram_addra);
        fwd_data_d = fwd_hit_d ? ram_data_a : fwd_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            fwd_hit_q  <= fwd_hit_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    assign rd_data = fwd_hit_q ? fwd_data_q : ram_data_b;
`else
    assign rd_data = ram_data_b;
`endif

endmodule

// File: tb/tb_tpram_arbiter.sv
// Bench for tpram_arbiter: behavioural RAM, vector table with hand-derived grants, read-return scoreboard.
module tb_tpram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        w0_req, w1_req, r0_req, r1_req;
    logic [7:0]  w0_addr, w1_addr, r0_addr, r1_addr;
    logic [15:0] w0_data, w1_data;
    logic        w0_gnt, w1_gnt, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
    logic [15:0] rd_data;
    logic        ram_wea, ram_enb;
    logic [7:0]  ram_addra, ram_addrb;
    logic [15:0] ram_data_a, ram_data_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tpram_arbiter #(.AW(8), .DW(16)) dut (
        .clk(clk), .rst(rst),
        .w0_req(w0_req), .w0_addr(w0_addr), .w0_data(w0_data), .w0_gnt(w0_gnt),
        .w1_req(w1_req), .w1_addr(w1_addr), .w1_data(w1_data), .w1_gnt(w1_gnt),
        .r0_req(r0_req), .r0_addr(r0_addr), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
        .r1_req(r1_req), .r1_addr(r1_addr), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
        .rd_data(rd_data),
        .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_data_a(ram_data_a),
        .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_data_b(ram_data_b)
    );

    // Behavioural RAM: read-before-write on a same-address collision.
    logic [15:0] ram_mem [256];
    logic [15:0] model_mem [256];
    always @(posedge clk) begin
        if (ram_wea) ram_mem[ram_addra] <= ram_data_a;
        if (ram_enb) ram_data_b <= ram_mem[ram_addrb];
    end

    typedef struct {
        logic        do_rst;
        logic        w0r; logic [7:0] w0a; logic [15:0] w0d;
        logic        w1r; logic [7:0] w1a; logic [15:0] w1d;
        logic        r0r; logic [7:0] r0a;
        logic        r1r; logic [7:0] r1a;
        logic [1:0]  exp_w;  // 0 none, 1 client 0, 2 client 1
        logic [1:0]  exp_r;
    } vec_t;

    typedef struct {
        logic        valid;
        logic        owner;
        logic [15:0] data;
    } rd_exp_t;

    vec_t    vecs[$];
    rd_exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        w0_req = 1'b0; w0_addr = 8'h00; w0_data = 16'h0000;
        w1_req = 1'b0; w1_addr = 8'h00; w1_data = 16'h0000;
        r0_req = 1'b0; r0_addr = 8'h00;
        r1_req = 1'b0; r1_addr = 8'h00;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " gnts"}, {28'd0, w0_gnt, w1_gnt, r0_gnt, r1_gnt}, 32'd0);
        check({tag, " ram_en"}, {30'd0, ram_wea, ram_enb}, 32'd0);
        check({tag, " rvalid"}, {30'd0, r0_rvalid, r1_rvalid}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        #1 check_quiet("in_reset");
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        sb.push_back('{1'b0, 1'b0, 16'h0000});
    endtask

    task automatic apply_row(input vec_t v, input int idx);
        rd_exp_t     e;
        logic [7:0]  raddr, waddr;
        logic [15:0] wdata, rexp;
        if (v.do_rst) do_reset();
        @(negedge clk);
        w0_req = v.w0r; w0_addr = v.w0a; w0_data = v.w0d;
        w1_req = v.w1r; w1_addr = v.w1a; w1_data = v.w1d;
        r0_req = v.r0r; r0_addr = v.r0a;
        r1_req = v.r1r; r1_addr = v.r1a;
        #1;
        if (sb.size() > 0) e = sb.pop_front();
        else e = '{1'b0, 1'b0, 16'h0000};
        check($sformatf("row%0d r0_rvalid", idx), {31'd0, r0_rvalid}, {31'd0, e.valid & ~e.owner});
        check($sformatf("row%0d r1_rvalid", idx), {31'd0, r1_rvalid}, {31'd0, e.valid & e.owner});
        if (e.valid) check($sformatf("row%0d rd_data", idx), {16'd0, rd_data}, {16'd0, e.data});

        waddr = (v.exp_w == 2'd2) ? v.w1a : v.w0a;
        wdata = (v.exp_w == 2'd2) ? v.w1d : v.w0d;
        raddr = (v.exp_r == 2'd2) ? v.r1a : v.r0a;
        check($sformatf("row%0d w_gnt", idx), {30'd0, w1_gnt, w0_gnt}, {30'd0, v.exp_w});
        check($sformatf("row%0d r_gnt", idx), {30'd0, r1_gnt, r0_gnt}, {30'd0, v.exp_r});
        check($sformatf("row%0d ram_wea", idx), {31'd0, ram_wea}, {31'd0, v.exp_w != 2'd0});
        check($sformatf("row%0d ram_addra", idx), {24'd0, ram_addra}, {24'd0, waddr});
        check($sformatf("row%0d ram_data_a", idx), {16'd0, ram_data_a}, {16'd0, wdata});
        check($sformatf("row%0d ram_enb", idx), {31'd0, ram_enb}, {31'd0, v.exp_r != 2'd0});
        check($sformatf("row%0d ram_addrb", idx), {24'd0, ram_addrb}, {24'd0, raddr});

        if (v.exp_r != 2'd0) begin
            rexp = model_mem[raddr];
`ifdef TPRAM_ARB_WR_FWD_EN
            if (v.exp_w != 2'd0 && waddr == raddr) rexp = wdata;
`endif
            sb.push_back('{1'b1, v.exp_r == 2'd2, rexp});
        end else begin
            sb.push_back('{1'b0, 1'b0, 16'h0000});
        end
        if (v.exp_w != 2'd0) model_mem[waddr] = wdata;
    endtask

    initial begin
        clear_inputs();
        for (int i = 0; i < 256; i++) begin
            ram_mem[i]   = {i[7:0], ~i[7:0]};
            model_mem[i] = {i[7:0], ~i[7:0]};
        end
        ram_mem[8'h01] = 16'h1111; model_mem[8'h01] = 16'h1111;
        ram_mem[8'h02] = 16'h2222; model_mem[8'h02] = 16'h2222;
        ram_mem[8'h20] = 16'h1234; model_mem[8'h20] = 16'h1234;

        //                  rst   w0r   w0a    w0d        w1r   w1a    w1d        r0r   r0a    r1r   r1a    ew    er
        vecs.push_back(vec_t'{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0, 2'd0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 8'h10, 16'hABCD, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0, 8'h00, 2'd1, 2'd0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b1, 8'h10, 2'd0, 2'd2});
        vecs.push_back(vec_t'{1'b0, 1'b0, 8'h33, 16'h3333, 1'b0, 8'h44, 16'h4444, 1'b0, 8'h55, 1'b0, 8'h66, 2'd0, 2'd0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h50, 16'h7777, 1'b0, 8'h00, 1'b0, 8'h00, 2'd2, 2'd0});
        // Continuous write contention from reset: w0, w1, w0, w1, w0, w1.
        vecs.push_back(vec_t'{1'b1, 1'b1, 8'h40, 16'hA001, 1'b1, 8'h41, 16'hB001, 1'b0, 8'h00, 1'b0, 8'h00, 2'd1, 2'd0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 8'h40, 16'hA002, 1'b1, 8'h41, 16'hB001, 1'b0, 8'h00, 1'b0, 8'h00, 2'd2, 2'd0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 8'h40, 16'hA002, 1'b1, 8'h41, 16'hB002, 1'b0, 8'h00, 1'b0, 8'h00, 2'd1, 2'd0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 8'h40, 16'hA003, 1'b1, 8'h41, 16'hB002, 1'b0, 8'h00, 1'b0, 8'h00, 2'd2, 2'd0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 8'h40, 16'hA003, 1'b1, 8'h41, 16'hB003, 1'b0, 8'h00, 1'b0, 8'h00, 2'd1, 2'd0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 8'h40, 16'hA004, 1'b1, 8'h41, 16'hB003, 1'b0, 8'h00, 1'b0, 8'h00, 2'd2, 2'd0});
        // Back-to-back read contention on 0x01 / 0x02.
        vecs.push_back(vec_t'{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h01, 1'b1, 8'h02, 2'd0, 2'd1});
        vecs.push_back(vec_t'{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h01, 1'b1, 8'h02, 2'd0, 2'd2});
        vecs.push_back(vec_t'{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h01, 1'b1, 8'h02, 2'd0, 2'd1});
        vecs.push_back(vec_t'{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h01, 1'b1, 8'h02, 2'd0, 2'd2});
        vecs.push_back(vec_t'{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0, 2'd0});
        // Same-cycle write/read collision on 0x20, then a later read of the committed value.
        vecs.push_back(vec_t'{1'b0, 1'b1, 8'h20, 16'h5555, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h20, 1'b0, 8'h00, 2'd1, 2'd1});
        vecs.push_back(vec_t'{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0, 2'd0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b1, 8'h20, 2'd0, 2'd2});
        vecs.push_back(vec_t'{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0, 2'd0});

        do_reset();
        foreach (vecs[i]) apply_row(vecs[i], i);

        // Reset right after an r0 grant: the pending read is dropped and both pointers return to client 0.
        do_reset();
        @(negedge clk);
        w0_req = 1'b1; w0_addr = 8'h60; w0_data = 16'h0606;
        r0_req = 1'b1; r0_addr = 8'h01;
        #1 check("pre_rst grants", {30'd0, w0_gnt, r0_gnt}, 32'd3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        w1_req = 1'b1; w1_addr = 8'h61; w1_data = 16'h0616;
        r1_req = 1'b1; r1_addr = 8'h02;
        #1 check_quiet("rst_after_grant");
        @(negedge clk);
        #1 check_quiet("rst_held");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst r0_rvalid", {31'd0, r0_rvalid}, 32'd0);
        check("post_rst w_gnt", {30'd0, w1_gnt, w0_gnt}, 32'd1);
        check("post_rst r_gnt", {30'd0, r1_gnt, r0_gnt}, 32'd1);
        @(negedge clk);
        clear_inputs();
        #1;
        check("post_rst read r0_rvalid", {30'd0, r1_rvalid, r0_rvalid}, 32'd1);
        check("post_rst read rd_data", {16'd0, rd_data}, 32'h1111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
